// File: rtl/split_vector_driver_if.sv
// Bundle between the stimulus driver (master) and its host/checker side (slave).
interface split_vector_driver_if #(
    parameter int VEC_W = 256
);
    logic             seed_load;
    logic [31:0]      seed;
    logic             start;
    logic [15:0]      num_samples;
    logic [VEC_W-1:0] vec_out;
    logic             vec_valid;
    logic             x_in;
    logic             busy;
    logic             done;
    logic [15:0]      sat_count;
    logic             sat_found;
    logic [VEC_W-1:0] sat_vec;

    // Driver side: takes control and the checker result, produces vectors and results.
    modport master (
        input  seed_load, seed, start, num_samples, x_in,
        output vec_out, vec_valid, busy, done, sat_count, sat_found, sat_vec
    );

    // Host/checker side: the mirror image of the driver.
    modport slave (
        output seed_load, seed, start, num_samples, x_in,
        input  vec_out, vec_valid, busy, done, sat_count, sat_found, sat_vec
    );
endinterface

// File: rtl/split_vector_driver.sv
// Pseudo-random assignment generator for a split constraint checker: builds
// each vector from a 32-bit Galois LFSR one word per cycle, waits out the
// checker latency, samples x_in and tallies / captures satisfying vectors.
module split_vector_driver #(
    parameter int VEC_W   = 256,
    parameter int CHK_LAT = 0
) (
    input logic                   clk,
    input logic                   rst,
    split_vector_driver_if.master bus
);
    localparam int          CHUNKS     = (VEC_W + 31) / 32;
    localparam int          CIDX_W     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int          WAIT_W     = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
    localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(CHUNKS - 1);
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
    localparam logic [31:0] LFSR_INIT  = 32'h0000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [31:0]        lfsr_q,      lfsr_d;
    logic [CIDX_W-1:0]  chunk_q,     chunk_d;
    logic [15:0]        remain_q,    remain_d;
    logic [WAIT_W-1:0]  wait_q,      wait_d;
    logic [VEC_W-1:0]   vec_out_q,   vec_out_d;
    logic               vec_valid_q, vec_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [15:0]        sat_count_q, sat_count_d;
    logic               sat_found_q, sat_found_d;
    logic [VEC_W-1:0]   sat_vec_q,   sat_vec_d;
    logic [31:0]        lfsr_nxt;

    // Right-shifting Galois step: shift out bit 0 and fold the mask back in when it was set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // Next-state and next-output logic for the whole run sequencer.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path through the case leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        chunk_d     = chunk_q;
        remain_d    = remain_q;
        wait_d      = wait_q;
        vec_out_d   = vec_out_q;
        sat_count_d = sat_count_q;
        sat_found_d = sat_found_q;
        sat_vec_d   = sat_vec_q;
        done_d      = 1'b0;
        lfsr_nxt    = lfsr_step(lfsr_q);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Seed goes in before any step, so a same-cycle start runs from the new seed.
                if (bus.seed_load) begin
                    lfsr_d = (bus.seed == 32'd0) ? LFSR_INIT : bus.seed;
                end
                if (bus.start) begin
                    sat_count_d = 16'd0;
                    sat_found_d = 1'b0;
                    sat_vec_d   = '0;
                    remain_d    = bus.num_samples;
                    chunk_d     = '0;
                    if (bus.num_samples == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GEN;
                    end
                end
            end

            S_GEN: begin
                lfsr_d = lfsr_nxt;
                // Bits of the final word beyond VEC_W simply have no destination.
                for (int b = 0; b < VEC_W; b++) begin
                    if ((b / 32) == int'(chunk_q)) begin
                        vec_out_d[b] = lfsr_nxt[b % 32];
                    end
                end
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    if (CHK_LAT == 0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_W'(CHK_LAT - 1);
                    end
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            S_SAMPLE: begin
                if (bus.x_in) begin
                    if (sat_count_q != 16'hFFFF) begin
                        sat_count_d = sat_count_q + 16'd1;
                    end
                    if (!sat_found_q) begin
                        sat_found_d = 1'b1;
                        sat_vec_d   = vec_out_q;
                    end
                end
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_GEN;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the state being entered so they line up with it.
        busy_d      = (state_d inside {S_GEN, S_WAIT, S_SAMPLE});
        vec_valid_d = (state_d inside {S_WAIT, S_SAMPLE});
    end

    // State and output registers; reset aborts a run without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_INIT;
            chunk_q     <= '0;
            remain_q    <= 16'd0;
            wait_q      <= '0;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_count_q <= 16'd0;
            sat_found_q <= 1'b0;
            sat_vec_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            chunk_q     <= chunk_d;
            remain_q    <= remain_d;
            wait_q      <= wait_d;
            vec_out_q   <= vec_out_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_count_q <= sat_count_d;
            sat_found_q <= sat_found_d;
            sat_vec_q   <= sat_vec_d;
        end
    end

    assign bus.vec_out   = vec_out_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sat_count = sat_count_q;
    assign bus.sat_found = sat_found_q;
    assign bus.sat_vec   = sat_vec_q;
endmodule

// File: tb/tb_split_vector_driver.sv
// Bench for split_vector_driver: a combinational-checker instance (64-bit bus)
// and a latency-2 instance (40-bit bus, truncated last word), each checked
// against a vector-list model built directly from the LFSR rule.
module tb_split_vector_driver;
    localparam int          NCH       = 2;             // words per vector for both widths used
    localparam int          L_OF[2]   = '{3, 5};       // cycles per vector: NCH + CHK_LAT + 1
    localparam int          W_OF[2]   = '{64, 40};
    localparam logic [31:0] MASK      = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    split_vector_driver_if #(.VEC_W(64)) if0 ();
    split_vector_driver_if #(.VEC_W(40)) if2 ();

    split_vector_driver #(.VEC_W(64), .CHK_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    split_vector_driver #(.VEC_W(40), .CHK_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Stimulus, steered to the selected instance.
    logic        sel = 1'b0;
    logic        start_drv = 1'b0;
    logic        seed_load_drv = 1'b0;
    logic [31:0] seed_drv = 32'd0;
    logic [15:0] num_drv = 16'd0;
    logic        x_drv = 1'b0;

    assign if0.start       = start_drv & ~sel;
    assign if2.start       = start_drv & sel;
    assign if0.seed_load   = seed_load_drv & ~sel;
    assign if2.seed_load   = seed_load_drv & sel;
    assign if0.seed        = seed_drv;
    assign if2.seed        = seed_drv;
    assign if0.num_samples = num_drv;
    assign if2.num_samples = num_drv;
    assign if0.x_in        = x_drv;
    assign if2.x_in        = x_drv;

    // Observed outputs of the selected instance, widened to 64 bits.
    logic [63:0] vo, sv;
    logic        done_s, busy_s, valid_s, found_s;
    logic [15:0] cnt_s;
    assign vo      = sel ? 64'(if2.vec_out) : if0.vec_out;
    assign sv      = sel ? 64'(if2.sat_vec) : if0.sat_vec;
    assign done_s  = sel ? if2.done      : if0.done;
    assign busy_s  = sel ? if2.busy      : if0.busy;
    assign valid_s = sel ? if2.vec_valid : if0.vec_valid;
    assign found_s = sel ? if2.sat_found : if0.sat_found;
    assign cnt_s   = sel ? if2.sat_count : if0.sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: LFSR and last presented vector, per instance.
    logic [31:0] m_lfsr[2];
    logic [63:0] m_vec[2];
    logic [63:0] got_sv;

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic b;
        b = s[0];
        s = s >> 1;
        if (b) s = s ^ MASK;
        return s;
    endfunction

    // One full vector for instance d: consecutive LFSR states packed word by word, cut to the bus width.
    function automatic logic [63:0] model_vec(input int d);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            m_lfsr[d] = lfsr_adv(m_lfsr[d]);
            v[32*c +: 32] = m_lfsr[d];
        end
        if (W_OF[d] < 64) v = v & ((64'd1 << W_OF[d]) - 64'd1);
        return v;
    endfunction

    // Full run on instance d. xmode: 0 tied low, 1 tied high, 2 random, 3 high only when sampling vector 1.
    // noise: toggle start/seed_load/seed/num_samples randomly while busy.
    task automatic do_run(input int d, input logic load, input logic [31:0] sd, input int n,
                          input int xmode, input logic noise, input string name);
        logic [63:0] exp_v[$];
        logic [63:0] sv_exp, last_exp;
        logic        found_exp, xv, samp;
        int          nl, k, L, cnt_exp, vec_bad, ctl_bad;
        L = L_OF[d];
        if (load) m_lfsr[d] = (sd == 32'd0) ? 32'd1 : sd;
        for (int v = 0; v < n; v++) exp_v.push_back(model_vec(d));
        last_exp = (n > 0) ? exp_v[n-1] : m_vec[d];
        m_vec[d] = last_exp;
        nl = n * L;
        cnt_exp = 0; found_exp = 1'b0; sv_exp = '0; vec_bad = 0; ctl_bad = 0;

        @(negedge clk);
        sel = (d == 1); seed_drv = sd; seed_load_drv = load; num_drv = 16'(n);
        start_drv = 1'b1; x_drv = 1'b0;
        @(negedge clk);
        start_drv = 1'b0; seed_load_drv = 1'b0;
        k = 0;
        forever begin
            if (busy_s !== (k < nl)) ctl_bad++;
            if (valid_s !== ((k < nl) && ((k % L) >= NCH))) ctl_bad++;
            if ((k < nl) && ((k % L) >= NCH) && (vo !== exp_v[k / L])) vec_bad++;
            if (done_s === 1'b1 || k >= nl + 20) break;
            samp = (k < nl) && ((k % L) == L - 1);
            case (xmode)
                0:       xv = 1'b0;
                1:       xv = 1'b1;
                2:       xv = 1'($urandom_range(0, 1));
                default: xv = samp ? ((k / L) == 1) : 1'($urandom_range(0, 1));
            endcase
            if (samp && xv) begin
                if (cnt_exp < 65535) cnt_exp++;
                if (!found_exp) begin
                    found_exp = 1'b1;
                    sv_exp = exp_v[k / L];
                end
            end
            x_drv = xv;
            if (noise && k < nl) begin
                start_drv     = 1'($urandom_range(0, 1));
                seed_load_drv = 1'($urandom_range(0, 1));
                seed_drv      = $urandom;
                num_drv       = 16'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start_drv = 1'b0; seed_load_drv = 1'b0; x_drv = 1'b0;
        got_sv = sv;

        n_tests++;
        if (done_s !== 1'b1 || k != nl) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d cycles (done=%b), want %0d", name, k, done_s, nl);
        end
        n_tests++;
        if (cnt_s !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL %s sat_count: got %0d, want %0d", name, cnt_s, cnt_exp);
        end
        n_tests++;
        if (found_s !== found_exp) begin
            n_fail++;
            $display("FAIL %s sat_found: got %b, want %b", name, found_s, found_exp);
        end
        n_tests++;
        if (sv !== sv_exp) begin
            n_fail++;
            $display("FAIL %s sat_vec: got %h, want %h", name, sv, sv_exp);
        end
        n_tests++;
        if (vo !== last_exp) begin
            n_fail++;
            $display("FAIL %s final vec_out: got %h, want %h", name, vo, last_exp);
        end
        n_tests++;
        if (vec_bad != 0) begin
            n_fail++;
            $display("FAIL %s vec_out_stream: got %0d mismatching valid cycles, want 0", name, vec_bad);
        end
        n_tests++;
        if (ctl_bad != 0) begin
            n_fail++;
            $display("FAIL %s busy_valid_timing: got %0d wrong cycles, want 0", name, ctl_bad);
        end
        @(negedge clk);
        n_tests++;
        if (done_s !== 1'b0 || cnt_s !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL %s done_one_shot: got done=%b count=%0d, want done=0 count=%0d",
                     name, done_s, cnt_s, cnt_exp);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            n_tests++;
            if (vo !== 64'd0 || sv !== 64'd0 || cnt_s !== 16'd0 ||
                {valid_s, busy_s, done_s, found_s} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got vo=%h sv=%h cnt=%0d flags=%b, want all zero",
                         d, vo, sv, cnt_s, {valid_s, busy_s, done_s, found_s});
            end
        end
        @(negedge clk);
        #2 rst = 1'b0;
        m_lfsr[0] = 32'd1; m_lfsr[1] = 32'd1;
        m_vec[0] = '0;     m_vec[1] = '0;
        @(negedge clk);
        n_tests++;
        if (vo !== 64'd0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got vo=%h busy=%b done=%b, want 0/0/0", vo, busy_s, done_s);
        end
    endtask

    // The first vector from seed 1 is fixed by the LFSR rule: 80200003, then C0300002.
    task automatic test_tied_one();
        do_run(0, 1'b1, 32'd1, 3, 1, 1'b0, "tied_one");
        n_tests++;
        if (got_sv !== 64'hC0300002_80200003) begin
            n_fail++;
            $display("FAIL tied_one first_vector: got %h, want %h", got_sv, 64'hC0300002_80200003);
        end
    endtask

    task automatic test_tied_zero();
        do_run(0, 1'b0, 32'd0, 5, 0, 1'b0, "tied_zero");
    endtask

    task automatic test_zero_len();
        do_run(0, 1'b0, 32'd0, 0, 1, 1'b0, "zero_len");
    endtask

    task automatic test_chk_lat();
        do_run(1, 1'b1, 32'd1, 4, 3, 1'b0, "chk_lat2");
    endtask

    // Seed 0 must act as seed 1; the model applies that substitution.
    task automatic test_seed_zero();
        do_run(0, 1'b1, 32'd0, 4, 2, 1'b0, "seed0");
        do_run(0, 1'b1, 32'd1, 4, 2, 1'b0, "seed1");
        do_run(1, 1'b1, 32'd0, 3, 2, 1'b0, "seed0_lat2");
    endtask

    task automatic test_busy_ignore();
        do_run(0, 1'b1, 32'h1234_5678, 6, 2, 1'b1, "busy_ignore");
        do_run(1, 1'b0, 32'd0, 5, 2, 1'b1, "busy_ignore_lat2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int          d, n;
            logic        load;
            logic [31:0] sd;
            d    = i % 2;
            load = ($urandom_range(0, 2) != 0);
            sd   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            n    = $urandom_range(1, 12);
            do_run(d, load, sd, n, 2, (i >= 4), "random");
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        m_lfsr[0] = 32'd1;
        @(negedge clk);
        sel = 1'b0; seed_drv = 32'd1; seed_load_drv = 1'b1; num_drv = 16'd3;
        start_drv = 1'b1; x_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0; seed_load_drv = 1'b0;
        // Four more edges: vector 0 sampled, vector 1 has its first word written.
        repeat (4) @(negedge clk);
        n_tests++;
        if (cnt_s !== 16'd1 || busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid pre: got count=%0d busy=%b, want 1/1", cnt_s, busy_s);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (vo !== 64'd0 || sv !== 64'd0 || cnt_s !== 16'd0 ||
            {valid_s, busy_s, done_s, found_s} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid async: got vo=%h sv=%h cnt=%0d flags=%b, want all zero",
                     vo, sv, cnt_s, {valid_s, busy_s, done_s, found_s});
        end
        x_drv = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_s !== 1'b0) cyc++;
        end
        #2 rst = 1'b0;
        m_lfsr[0] = 32'd1; m_lfsr[1] = 32'd1;
        m_vec[0] = '0;     m_vec[1] = '0;
        repeat (3) begin
            @(negedge clk);
            if (done_s !== 1'b0) cyc++;
        end
        n_tests++;
        if (cyc != 0) begin
            n_fail++;
            $display("FAIL reset_mid no_done: got %0d cycles with done, want 0", cyc);
        end
        // Fresh run without a seed load: the LFSR is back at its reset value.
        do_run(0, 1'b0, 32'd0, 3, 1, 1'b0, "rerun");
        n_tests++;
        if (got_sv !== 64'hC0300002_80200003) begin
            n_fail++;
            $display("FAIL rerun first_vector: got %h, want %h", got_sv, 64'hC0300002_80200003);
        end
    endtask

    initial begin
        test_reset();
        test_tied_one();
        test_tied_zero();
        test_zero_len();
        test_chk_lat();
        test_seed_zero();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running after 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/split_vector_driver.md
Name: split_vector_driver

Overview:
- Sequential stimulus source for the combinational constraint-split checkers.
- A checker consumes a packed assignment of all its variables and returns a single satisfied bit `x`; this block produces those assignments.
- Per run it generates `num_samples` pseudo-random assignment vectors from a 32-bit LFSR, presents each one to the checker, samples `x`, counts satisfying vectors, and captures the first satisfying vector.
- It sits between the host/sequencer and one split checker instance.

Parameters:
- VEC_W, 256, width of the packed assignment bus (sum of all checker input widths); must be ≥ 1.
- CHK_LAT, 0, checker latency in cycles from `vec_out` stable to `x_in` valid (0 = combinational checker).
- CHUNKS, ceil(VEC_W/32), derived and not overridable: number of LFSR words per vector.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- seed_load  input  1  load `seed` into the LFSR; honoured only in IDLE or DONE.
- seed  input  32  LFSR seed; a value of 0 is replaced by 32'h00000001.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- num_samples  input  16  number of vectors to evaluate; latched on `start`.
- vec_out  output  VEC_W  packed assignment driven to the checker.
- vec_valid  output  1  `vec_out` is complete and stable.
- x_in  input  1  checker result `x`.
- busy  output  1  high in GEN, WAIT and SAMPLE.
- done  output  1  one-cycle pulse on entry to DONE.
- sat_count  output  16  number of sampled vectors with `x_in` = 1; saturates at 16'hFFFF.
- sat_found  output  1  at least one satisfying vector seen this run.
- sat_vec  output  VEC_W  first satisfying vector of the run.

Behaviour:
- Reset values: LFSR = 32'h00000001; state = IDLE; `vec_out` = 0; `sat_vec` = 0; `sat_count` = 0; `vec_valid`, `busy`, `done`, `sat_found` = 0. Reset mid-run aborts immediately with no `done` pulse.
- LFSR: right-shifting Galois, mask 32'h80200003. One step per cycle in GEN only:
  - b = s[0]; s = s >> 1; if b then s = s ^ mask.
  - The new state is written to `vec_out` chunk k (bits [32k+31:32k]); chunk 0 is written first.
  - The last chunk is truncated to VEC_W; surplus LFSR bits are discarded.
  - The LFSR is never reset between runs, only by rst or `seed_load`.
- seed_load and start in the same cycle: the seed is loaded first, and the first step of the run uses the new seed.
- States:
  - IDLE: on `start`, latch N = `num_samples`, clear `sat_count`, `sat_found` and `sat_vec`. If N = 0, go to DONE; else go to GEN with chunk index 0 and remaining count = N.
  - GEN: CHUNKS cycles, one chunk per cycle, then go to WAIT. `vec_valid` = 0.
  - WAIT: `vec_valid` = 1 for CHK_LAT cycles; with CHK_LAT = 0 it passes straight to SAMPLE with no extra cycle.
  - SAMPLE: one cycle, `vec_valid` = 1, `x_in` sampled.
    - If `x_in` = 1: increment `sat_count` (saturating); if `sat_found` = 0, copy `vec_out` into `sat_vec` and set `sat_found`.
    - Decrement the remaining count. If it reaches 0, go to DONE; else go to GEN.
  - DONE: `done` = 1 for the entry cycle only. Results and `vec_out` hold. On `start`, behave as IDLE.
- Per-vector latency: CHUNKS + CHK_LAT + 1 cycles. Run length: N·(CHUNKS + CHK_LAT + 1) cycles from `start` to `done`.
- `vec_out` changes only in GEN, so it is stable whenever `vec_valid` = 1.
- `start` and `seed_load` while busy are ignored, with no effect on the run or the LFSR.
- `x_in` outside the SAMPLE cycle is ignored.

Test Plan:
- VEC_W=64, CHK_LAT=0, seed=1, `start`, N=3, `x_in` tied 1 → `done` pulse 9 cycles after `start`; `sat_count` = 3; `sat_found` = 1; `sat_vec` = first vector, i.e. chunk0 = 32'h80200003, chunk1 = next LFSR state per the mask; checked against the reference model.
- `x_in` tied 0, N=5 → `sat_count` = 0, `sat_found` = 0, `sat_vec` = 0, `done` after 15 cycles.
- N=0 → `done` pulse in the cycle after `start`; `busy` never asserted; `sat_count` = 0.
- CHK_LAT=2, `x_in` driven 1 only in SAMPLE cycles of the 2nd vector, N=4 → `sat_count` = 1 and `sat_vec` = 2nd vector; `x_in` pulses in WAIT cycles are not counted.
- seed=0 vs seed=1, same run → identical `vec_out` sequences. `start` pulsed while busy → ignored, with no change to the sequence or count.
- Assert rst in the middle of the 2nd vector's GEN → all outputs return to reset values asynchronously; no `done` pulse. After release, a new run from seed 1 reproduces the first test exactly.
